// File: rtl/yc_dac_fmt.sv
// yc_dac_fmt - luma/chroma/CVBS formatter for a video DAC.
//
// Takes the upstream encoder word {C, Y, 8'd0} plus composite sync and
// blanking, tracks the sync structure with a small FSM, and produces DAC codes
// {C_o, Y_o, CV_o} two clocks after the input sample.
//
// Ports:
//   clk        pixel/encoder clock, rising edge
//   reset      synchronous, active-high
//   PAL_EN     1 = PAL (setup pedestal never applied)
//   SETUP_EN   1 = apply SETUP_LVL pedestal in NTSC active video
//   din        {C[23:16], Y[15:8], unused[7:0]}, C offset-binary around 128
//   csync      composite sync, active-low, aligned with din
//   blank      active-high blanking, aligned with din
//   dout       {C_o, Y_o, CV_o}
//   csync_o    csync delayed to line up with dout
//   vsync_det  one-cycle pulse at the end of a broad (vertical) sync pulse
//   sync_err   sticky flag: sync held low for SYNC_TIMEOUT cycles
module yc_dac_fmt #(
  parameter logic [7:0]  BLANK_LVL    = 8'd64,
  parameter logic [7:0]  SYNC_LVL     = 8'd4,
  parameter logic [7:0]  SETUP_LVL    = 8'd10,
  parameter logic [10:0] BP_LEN       = 11'd200,
  parameter logic [10:0] SYNC_TIMEOUT = 11'd1500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PAL_EN,
  input  logic        SETUP_EN,
  input  logic [23:0] din,
  input  logic        csync,
  input  logic        blank,
  output logic [23:0] dout,
  output logic        csync_o,
  output logic        vsync_det,
  output logic        sync_err
);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SYNC   = 2'd1,
    ST_BPORCH = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  // Sync pulses longer than 4/5 of the back porch are broad (vertical) pulses.
  localparam logic [12:0] BROAD_MIN_W = (13'(BP_LEN) * 13'd4) / 13'd5;
  localparam logic [10:0] BROAD_MIN   = BROAD_MIN_W[10:0];
  localparam logic [10:0] WIDTH_MAX   = '1;

  // Stage 1: registered input sample
  logic [7:0]  c1_q, c1_d;
  logic [7:0]  y1_q, y1_d;
  logic        blank1_q, blank1_d;
  logic        setup1_q, setup1_d;
  logic        csync1_q, csync1_d;
  logic        csync2_q, csync2_d;
  // Edge-detect qualification after reset
  logic        vld_q, vld_d;
  logic        arm_q, arm_d;

  // FSM and counters
  state_t      state_q, state_d;
  logic [10:0] width_q, width_d;
  logic [10:0] bp_q, bp_d;

  // Stage 2: registered outputs
  logic [23:0] dout_q, dout_d;
  logic        vsync_q, vsync_d;
  logic        err_q, err_d;

  // Datapath intermediates
  logic        fall;
  logic        rise;
  logic [10:0] width_inc;
  logic [7:0]  setup_off;
  logic [9:0]  span_w;
  logic [7:0]  span;
  logic [15:0] prod;
  logic [9:0]  sum_w;
  logic [7:0]  y_act;
  logic [7:0]  y_o;
  logic [7:0]  c_o;
  logic signed [9:0] cv_s;
  logic [7:0]  cv_o;

  logic unused_bits;
  assign unused_bits = ^{din[7:0], prod[7:0]};

  always_comb begin
    // Input capture
    c1_d     = din[23:16];
    y1_d     = din[15:8];
    blank1_d = blank;
    setup1_d = SETUP_EN & ~PAL_EN;
    csync1_d = csync;
    csync2_d = csync1_q;

    // A falling edge only counts once csync has been seen high after reset,
    // so a sync already low when reset releases is not mistaken for an edge.
    vld_d = 1'b1;
    arm_d = arm_q | (vld_q & csync1_q);
    fall  = arm_q & csync2_q & ~csync1_q;
    rise  = ~csync2_q & csync1_q;

    width_inc = (width_q == WIDTH_MAX) ? width_q : width_q + 11'd1;

    state_d = state_q;
    width_d = width_q;
    bp_d    = bp_q;
    vsync_d = 1'b0;
    err_d   = err_q;

    // The entry sample of SYNC/BPORCH is counted as cycle 1 of that state.
    case (state_q)
      ST_ACTIVE: begin
        if (fall) begin
          state_d = ST_SYNC;
          width_d = 11'd1;
        end
      end
      ST_SYNC: begin
        if (rise) begin
          state_d = ST_BPORCH;
          bp_d    = 11'd1;
          vsync_d = (width_q > BROAD_MIN);
        end else begin
          width_d = width_inc;
          if (width_inc >= SYNC_TIMEOUT) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_BPORCH: begin
        if (fall) begin
          state_d = ST_SYNC;
          width_d = 11'd1;
        end else if (bp_q >= BP_LEN) begin
          state_d = ST_ACTIVE;
          bp_d    = '0;
        end else begin
          bp_d = bp_q + 11'd1;
        end
      end
      ST_FAULT: begin
        if (rise) begin
          state_d = ST_BPORCH;
          bp_d    = 11'd1;
        end
      end
      default: begin
        state_d = ST_ACTIVE;
      end
    endcase

    if (state_d == ST_FAULT) begin
      err_d = 1'b1;
    end

    // Active-video luma scaling: Y spans blank(+setup) .. 255
    setup_off = setup1_q ? SETUP_LVL : 8'd0;
    span_w    = 10'd255 - {2'b00, BLANK_LVL} - {2'b00, setup_off};
    span      = span_w[9] ? 8'd0 : span_w[7:0];
    prod      = {8'd0, y1_q} * {8'd0, span};
    sum_w     = {2'b00, BLANK_LVL} + {2'b00, setup_off} + {2'b00, prod[15:8]};
    y_act     = (sum_w > 10'd255) ? 8'd255 : sum_w[7:0];

    // The output sample belongs to the state being entered this cycle, so a
    // sync edge overrides active video on the very same sample.
    case (state_d)
      ST_SYNC, ST_FAULT: begin
        y_o = SYNC_LVL;
        c_o = 8'd128;
      end
      ST_BPORCH: begin
        y_o = BLANK_LVL;
        c_o = c1_q;
      end
      default: begin
        if (blank1_q) begin
          y_o = BLANK_LVL;
          c_o = 8'd128;
        end else begin
          y_o = y_act;
          c_o = c1_q;
        end
      end
    endcase

    cv_s = $signed({2'b00, y_o}) + $signed({2'b00, c_o}) - 10'sd128;
    if (cv_s < 10'sd0) begin
      cv_o = 8'd0;
    end else if (cv_s > 10'sd255) begin
      cv_o = 8'd255;
    end else begin
      cv_o = cv_s[7:0];
    end

    dout_d = {c_o, y_o, cv_o};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c1_q     <= 8'd128;
      y1_q     <= '0;
      blank1_q <= 1'b1;
      setup1_q <= 1'b0;
      csync1_q <= 1'b1;
      csync2_q <= 1'b1;
      vld_q    <= 1'b0;
      arm_q    <= 1'b0;
      state_q  <= ST_ACTIVE;
      width_q  <= '0;
      bp_q     <= '0;
      dout_q   <= {8'd128, BLANK_LVL, BLANK_LVL};
      vsync_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      c1_q     <= c1_d;
      y1_q     <= y1_d;
      blank1_q <= blank1_d;
      setup1_q <= setup1_d;
      csync1_q <= csync1_d;
      csync2_q <= csync2_d;
      vld_q    <= vld_d;
      arm_q    <= arm_d;
      state_q  <= state_d;
      width_q  <= width_d;
      bp_q     <= bp_d;
      dout_q   <= dout_d;
      vsync_q  <= vsync_d;
      err_q    <= err_d;
    end
  end

  assign dout      = dout_q;
  assign csync_o   = csync2_q;
  assign vsync_det = vsync_q;
  assign sync_err  = err_q;

endmodule

// File: tb/tb_yc_dac_fmt.sv
// tb_yc_dac_fmt - directed testbench for yc_dac_fmt (default parameters).
// Table of active-video formatting vectors plus hand-written sync sequences.
module tb_yc_dac_fmt;

  logic        clk = 1'b0;
  logic        reset;
  logic        PAL_EN;
  logic        SETUP_EN;
  logic [23:0] din;
  logic        csync;
  logic        blank;
  logic [23:0] dout;
  logic        csync_o;
  logic        vsync_det;
  logic        sync_err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  yc_dac_fmt #(
    .BLANK_LVL   (8'd64),
    .SYNC_LVL    (8'd4),
    .SETUP_LVL   (8'd10),
    .BP_LEN      (11'd200),
    .SYNC_TIMEOUT(11'd1500)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .PAL_EN   (PAL_EN),
    .SETUP_EN (SETUP_EN),
    .din      (din),
    .csync    (csync),
    .blank    (blank),
    .dout     (dout),
    .csync_o  (csync_o),
    .vsync_det(vsync_det),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pal;
    logic        setup;
    logic        blk;
    logic [7:0]  c;
    logic [7:0]  y;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[12];

  // Expected words for the sync-sequence stimulus C=150, Y=200, NTSC + setup
  localparam logic [23:0] EXP_SYNC   = {8'd128, 8'd4,   8'd4};
  localparam logic [23:0] EXP_BP     = {8'd150, 8'd64,  8'd86};   // 64+150-128
  localparam logic [23:0] EXP_ACTIVE = {8'd150, 8'd215, 8'd237};  // 74+(200*181>>8)
  localparam logic [23:0] EXP_RESET  = {8'd128, 8'd64,  8'd64};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives csync low for low_len samples then high for post samples and
  // checks every output sample against the expected sync structure.
  task automatic run_sync(input int unsigned low_len, input int unsigned post);
    int unsigned j;
    logic [23:0] e_dout;
    logic        e_cs, e_vs, e_err;
    for (int unsigned cyc = 0; cyc < low_len + post; cyc++) begin
      csync = (cyc < low_len) ? 1'b0 : 1'b1;
      step();
      if (cyc >= 1) begin
        j = cyc - 1;
        if (j < low_len) begin
          e_dout = EXP_SYNC;
          e_cs   = 1'b0;
        end else if (j < low_len + 200) begin
          e_dout = EXP_BP;
          e_cs   = 1'b1;
        end else begin
          e_dout = EXP_ACTIVE;
          e_cs   = 1'b1;
        end
        e_vs  = (j == low_len) && (low_len > 160) && (low_len < 1500);
        e_err = (low_len >= 1500) && (j >= 1499);
        check("seq_dout", dout, e_dout);
        check("seq_csync_o", {23'd0, csync_o}, {23'd0, e_cs});
        check("seq_vsync", {23'd0, vsync_det}, {23'd0, e_vs});
        check("seq_err", {23'd0, sync_err}, {23'd0, e_err});
      end
    end
  endtask

  initial begin
    // Y, C pairs chosen to exercise scaling, setup, PAL override and clamps
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'd128, 8'd255, {8'd128, 8'd254, 8'd254}};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'd128, 8'd0,   {8'd128, 8'd74,  8'd74}};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'd128, 8'd0,   {8'd128, 8'd64,  8'd64}};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'd128, 8'd0,   {8'd128, 8'd64,  8'd64}};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'd128, 8'd128, {8'd128, 8'd164, 8'd164}};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'd128, 8'd128, {8'd128, 8'd159, 8'd159}};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'd255, 8'd255, {8'd255, 8'd254, 8'd255}};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   {8'd0,   8'd64,  8'd0}};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'd200, 8'd200, {8'd128, 8'd64,  8'd64}};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'd100, 8'd100, {8'd100, 8'd138, 8'd110}};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 8'd160, 8'd200, {8'd160, 8'd213, 8'd245}};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'd140, 8'd200, {8'd140, 8'd215, 8'd227}};

    reset    = 1'b1;
    PAL_EN   = 1'b0;
    SETUP_EN = 1'b1;
    din      = {8'd77, 8'd200, 8'd0};
    csync    = 1'b1;
    blank    = 1'b0;
    step();
    step();
    step();
    check("rst_dout", dout, EXP_RESET);
    check("rst_csync_o", {23'd0, csync_o}, 24'd1);
    check("rst_vsync", {23'd0, vsync_det}, 24'd0);
    check("rst_err", {23'd0, sync_err}, 24'd0);

    reset = 1'b0;
    step();
    step();

    for (int unsigned i = 0; i < 12; i++) begin
      PAL_EN   = vecs[i].pal;
      SETUP_EN = vecs[i].setup;
      blank    = vecs[i].blk;
      din      = {vecs[i].c, vecs[i].y, 8'd0};
      step();
      step();
      check($sformatf("vec%0d", i), dout, vecs[i].exp);
    end

    // Sync sequences with a fixed active-video input
    PAL_EN   = 1'b0;
    SETUP_EN = 1'b1;
    blank    = 1'b0;
    din      = {8'd150, 8'd200, 8'd0};
    csync    = 1'b1;
    step();
    step();
    step();
    check("pre_seq_active", dout, EXP_ACTIVE);
    run_sync(100, 220);
    run_sync(180, 220);
    run_sync(1600, 220);
    check("err_sticky", {23'd0, sync_err}, 24'd1);

    // Reset in the middle of a sync pulse, csync still low on release
    csync = 1'b0;
    for (int unsigned i = 0; i < 20; i++) step();
    check("mid_sync_dout", dout, EXP_SYNC);
    reset = 1'b1;
    step();
    check("rst_sync_dout", dout, EXP_RESET);
    check("rst_sync_err", {23'd0, sync_err}, 24'd0);
    check("rst_sync_csync_o", {23'd0, csync_o}, 24'd1);
    reset = 1'b0;
    step();
    check("rel_dout", dout, EXP_RESET);
    for (int unsigned i = 0; i < 8; i++) begin
      step();
      check("low_at_release_dout", dout, EXP_ACTIVE);
    end
    check("low_at_release_csync_o", {23'd0, csync_o}, 24'd0);
    csync = 1'b1;
    step();
    step();
    csync = 1'b0;
    step();
    step();
    check("rearmed_sync_dout", dout, EXP_SYNC);

    // Reset during back porch
    csync = 1'b1;
    for (int unsigned i = 0; i < 30; i++) step();
    check("bp_dout", dout, EXP_BP);
    reset = 1'b1;
    step();
    check("rst_bp_dout", dout, EXP_RESET);
    check("rst_bp_vsync", {23'd0, vsync_det}, 24'd0);
    reset = 1'b0;
    step();
    step();
    check("after_bp_rst_active", dout, EXP_ACTIVE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
